// File: rtl/amm_test_sequencer_if.sv
// Avalon-MM master bus used by the test sequencer. The master modport drives
// address/command/writedata; the slave modport drives waitrequest and read data.
interface amm_test_sequencer_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 11
);
    logic [ADDR_W-1:0]   address_o;
    logic                read_o;
    logic                write_o;
    logic [BURST_W-1:0]  burstcount_o;
    logic [DATA_W/8-1:0] byteenable_o;
    logic [DATA_W-1:0]   writedata_o;
    logic                waitrequest_i;
    logic                readdatavalid_i;
    logic [DATA_W-1:0]   readdata_i;

    modport master (
        output address_o, read_o, write_o, burstcount_o, byteenable_o, writedata_o,
        input  waitrequest_i, readdatavalid_i, readdata_i
    );

    modport slave (
        input  address_o, read_o, write_o, burstcount_o, byteenable_o, writedata_o,
        output waitrequest_i, readdatavalid_i, readdata_i
    );
endinterface

// File: rtl/amm_test_sequencer.sv
// Avalon-MM burst traffic sequencer: write, read or write-then-read address-pattern test.
// Define SEQ_DATA_CHECK_EN to compare returned read data and count mismatches on err_cnt_o.
module amm_test_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 11,
    parameter int MAX_OUTST = 4,
    localparam int OUTST_W  = $clog2(MAX_OUTST + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [BURST_W-1:0]   burst_len_i,
    input  logic [15:0]          burst_num_i,
    amm_test_sequencer_if.master amm,
    output logic                 meas_start_o,
    input  logic                 meas_busy_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          err_cnt_o,
    output logic [2:0]           dbg_state_o,
    output logic [OUTST_W-1:0]   dbg_outst_o
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WR_BURST, S_RD_REQ, S_RD_DRAIN, S_FLUSH, S_DONE
    } state_t;

    state_t               r_state;
    logic [1:0]           r_mode;
    logic [ADDR_W-1:0]    r_base;
    logic [ADDR_W-1:0]    r_addr;
    logic [BURST_W-1:0]   r_len;
    logic [BURST_W-1:0]   r_word_idx;
    logic [BURST_W-1:0]   r_rd_beat;
    logic [15:0]          r_num;
    logic [15:0]          r_burst_cnt;
    logic [DATA_W-1:0]    r_wdata;
    logic [OUTST_W-1:0]   r_outst;
    logic                 r_read;
    logic                 r_write;
    logic                 r_meas_start;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_start;
    logic [BURST_W-1:0]   w_len_eff;
    logic                 w_wr_xfer;
    logic                 w_rd_acc;
    logic                 w_rd_last;
    logic                 w_dec;
    logic [OUTST_W-1:0]   w_outst_next;
    logic                 w_outst_room;
    logic                 w_last_burst;
    logic                 w_last_word;
    logic [ADDR_W-1:0]    w_next_addr;

    // Zero-extend (or truncate) a word address into the data-pattern width.
    function automatic logic [DATA_W-1:0] to_data(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+DATA_W-1:0] wide;
        wide = {{DATA_W{1'b0}}, a};
        return wide[DATA_W-1:0];
    endfunction

    // Handshake: a command (read or write word) is taken on a rising edge where it is
    // asserted and waitrequest_i is low; until then every command output holds steady.
    assign w_start      = start_i && (r_state == S_IDLE);
    assign w_len_eff    = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
    assign w_wr_xfer    = r_write && !amm.waitrequest_i;
    assign w_rd_acc     = r_read && !amm.waitrequest_i;
    assign w_rd_last    = amm.readdatavalid_i && (r_rd_beat == r_len - BURST_W'(1));
    assign w_dec        = w_rd_last && (r_outst != '0);
    assign w_outst_next = r_outst + OUTST_W'(w_rd_acc) - OUTST_W'(w_dec);
    assign w_outst_room = w_outst_next < OUTST_W'(MAX_OUTST);
    assign w_last_burst = (r_burst_cnt == r_num - 16'd1);
    assign w_last_word  = (r_word_idx == r_len - BURST_W'(1));
    assign w_next_addr  = r_addr + ADDR_W'(r_len);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_base       <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_rd_beat    <= '0;
            r_num        <= '0;
            r_burst_cnt  <= '0;
            r_wdata      <= '0;
            r_outst      <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_meas_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_outst <= w_outst_next;
            if (amm.readdatavalid_i)
                r_rd_beat <= w_rd_last ? '0 : r_rd_beat + BURST_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mode       <= mode_i;
                        r_base       <= base_addr_i;
                        r_len        <= w_len_eff;
                        r_num        <= burst_num_i;
                        r_rd_beat    <= '0;
                        r_meas_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_meas_start <= 1'b0;
                    r_addr       <= r_base;
                    r_burst_cnt  <= '0;
                    r_word_idx   <= '0;
                    r_wdata      <= to_data(r_base);
                    if (r_num == '0) begin
                        r_state <= S_FLUSH;
                    end else if (r_mode == 2'd1) begin
                        r_read  <= 1'b1;
                        r_state <= S_RD_REQ;
                    end else begin
                        r_write <= 1'b1;
                        r_state <= S_WR_BURST;
                    end
                end
                S_WR_BURST: begin
                    if (w_wr_xfer) begin
                        if (!w_last_word) begin
                            r_word_idx <= r_word_idx + BURST_W'(1);
                            r_wdata    <= to_data(r_addr + ADDR_W'(r_word_idx) + ADDR_W'(1));
                        end else if (!w_last_burst) begin
                            r_burst_cnt <= r_burst_cnt + 16'd1;
                            r_word_idx  <= '0;
                            r_addr      <= w_next_addr;
                            r_wdata     <= to_data(w_next_addr);
                        end else begin
                            r_write     <= 1'b0;
                            r_word_idx  <= '0;
                            r_burst_cnt <= '0;
                            if (r_mode == 2'd0) begin
                                r_state <= S_FLUSH;
                            end else begin
                                r_addr  <= r_base;
                                r_read  <= 1'b1;
                                r_state <= S_RD_REQ;
                            end
                        end
                    end
                end
                S_RD_REQ: begin
                    if (w_rd_acc) begin
                        if (w_last_burst) begin
                            r_read  <= 1'b0;
                            r_state <= S_RD_DRAIN;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + 16'd1;
                            r_addr      <= w_next_addr;
                            r_read      <= w_outst_room;
                        end
                    end else if (!r_read) begin
                        r_read <= w_outst_room;
                    end
                end
                S_RD_DRAIN: begin
                    if (w_outst_next == '0)
                        r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (!meas_busy_i) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign amm.address_o    = r_addr;
    assign amm.read_o       = r_read;
    assign amm.write_o      = r_write;
    assign amm.burstcount_o = r_len;
    assign amm.byteenable_o = {BE_W{r_write | r_read}};
    assign amm.writedata_o  = r_wdata;
    assign meas_start_o     = r_meas_start;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign dbg_state_o      = r_state;
    assign dbg_outst_o      = r_outst;

`ifdef SEQ_DATA_CHECK_EN
    // Read bursts are consecutive from base, so the expected word is a running address.
    logic [ADDR_W-1:0] r_chk_addr;
    logic [31:0]       r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_chk_addr <= '0;
            r_err_cnt  <= '0;
        end else if (w_start) begin
            r_chk_addr <= base_addr_i;
            r_err_cnt  <= '0;
        end else if (amm.readdatavalid_i) begin
            r_chk_addr <= r_chk_addr + ADDR_W'(1);
            if ((amm.readdata_i != to_data(r_chk_addr)) && (r_err_cnt != 32'hFFFF_FFFF))
                r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^amm.readdata_i;
    assign err_cnt_o      = '0;
`endif
endmodule

// File: tb/tb_amm_test_sequencer.sv
// Bench for amm_test_sequencer: Avalon slave model, transaction scoreboard and
// directed plus random test runs.
module tb_amm_test_sequencer;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_W   = 11;
    localparam int MAX_OUTST = 4;
    localparam int OUTST_W   = 3;
    localparam int WR_W      = ADDR_W + BURST_W + DATA_W;
    localparam int RD_W      = ADDR_W + BURST_W;

    logic                clk = 1'b0;
    logic                rst_i = 1'b0;
    logic                start_i = 1'b0;
    logic [1:0]          mode_i = '0;
    logic [ADDR_W-1:0]   base_addr_i = '0;
    logic [BURST_W-1:0]  burst_len_i = '0;
    logic [15:0]         burst_num_i = '0;
    logic                meas_busy_i = 1'b0;
    wire                 meas_start_o;
    wire                 busy_o;
    wire                 done_o;
    wire [31:0]          err_cnt_o;
    wire [2:0]           dbg_state_o;
    wire [OUTST_W-1:0]   dbg_outst_o;

    amm_test_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) amm();

    amm_test_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .base_addr_i(base_addr_i), .burst_len_i(burst_len_i), .burst_num_i(burst_num_i),
        .amm(amm), .meas_start_o(meas_start_o), .meas_busy_i(meas_busy_i),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
        .dbg_state_o(dbg_state_o), .dbg_outst_o(dbg_outst_o)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    logic [WR_W-1:0] exp_wr_q[$];
    logic [RD_W-1:0] exp_rd_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Slave model state
    logic [31:0] pend_addr[$];
    int          pend_len[$];
    int          pend_rdy[$];
    bit          wait_en = 1'b0;
    int          lat = 1;
    int          corrupt_left = 0;
    int          n_corrupt = 0;
    int          beat = 0;
    bit          rdv_last = 1'b0;
    int          bench_outst = 0;
    int          peak = 0;
    int          cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list every write word and read burst the test should produce.
    task automatic build_expected(input int mode, input logic [31:0] base, input int len, input int num);
        int le;
        logic [31:0] a;
        exp_wr_q.delete();
        exp_rd_q.delete();
        le = (len == 0) ? 1 : len;
        if (num == 0) return;
        if (mode != 1)
            for (int b = 0; b < num; b++) begin
                a = base + 32'(b * le);
                for (int w = 0; w < le; w++)
                    exp_wr_q.push_back({a, BURST_W'(le), a + 32'(w)});
            end
        if (mode != 0)
            for (int b = 0; b < num; b++)
                exp_rd_q.push_back({base + 32'(b * le), BURST_W'(le)});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave driver: random waitrequest, in-order read data after a latency.
    initial begin
        logic [31:0] d;
        amm.waitrequest_i   = 1'b0;
        amm.readdatavalid_i = 1'b0;
        amm.readdata_i      = '0;
        forever begin
            @(posedge clk);
            #1;
            amm.readdatavalid_i = 1'b0;
            rdv_last = 1'b0;
            if (!rst_i) begin
                amm.waitrequest_i = 1'b0;
            end else begin
                amm.waitrequest_i = wait_en ? ($urandom_range(0, 2) == 0) : 1'b0;
                if (pend_addr.size() > 0 && cyc >= pend_rdy[0] && !(wait_en && $urandom_range(0, 3) == 0)) begin
                    d = pend_addr[0] + 32'(beat);
                    if (corrupt_left > 0) begin
                        d = d ^ 32'h8000_0001;
                        corrupt_left--;
                        n_corrupt++;
                    end
                    amm.readdatavalid_i = 1'b1;
                    amm.readdata_i      = d;
                    rdv_last = (beat == pend_len[0] - 1);
                    if (rdv_last) begin
                        void'(pend_addr.pop_front());
                        void'(pend_len.pop_front());
                        void'(pend_rdy.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end
        end
    end

    // Monitor: compares every bus transfer against the scoreboard queues.
    bit              prev_wr_stall = 1'b0;
    bit              prev_rd_stall = 1'b0;
    logic [WR_W:0]   prev_wr_bus;
    logic [RD_W:0]   prev_rd_bus;
    logic [WR_W-1:0] e_wr;
    logic [RD_W-1:0] e_rd;

    always @(negedge clk) begin
        if (!rst_i) begin
            prev_wr_stall = 1'b0;
            prev_rd_stall = 1'b0;
        end else begin
            check("rw_exclusive", amm.read_o & amm.write_o, 0);
            check("outst_count", dbg_outst_o, bench_outst);
            if (amm.read_o) check("read_below_max", bench_outst < MAX_OUTST, 1);
            if (prev_wr_stall)
                check("wr_hold", {amm.write_o, amm.address_o, amm.burstcount_o, amm.writedata_o}, prev_wr_bus);
            if (prev_rd_stall)
                check("rd_hold", {amm.read_o, amm.address_o, amm.burstcount_o}, prev_rd_bus);
            if (amm.write_o && !amm.waitrequest_i) begin
                check("wr_expected", exp_wr_q.size() != 0, 1);
                check("wr_byteenable", amm.byteenable_o, 4'hF);
                if (exp_wr_q.size() != 0) begin
                    e_wr = exp_wr_q.pop_front();
                    check("wr_xfer", {amm.address_o, amm.burstcount_o, amm.writedata_o}, e_wr);
                end
            end
            if (amm.read_o && !amm.waitrequest_i) begin
                check("rd_expected", exp_rd_q.size() != 0, 1);
                check("rd_after_wr", exp_wr_q.size(), 0);
                if (exp_rd_q.size() != 0) begin
                    e_rd = exp_rd_q.pop_front();
                    check("rd_req", {amm.address_o, amm.burstcount_o}, e_rd);
                end
                pend_addr.push_back(amm.address_o);
                pend_len.push_back(int'(amm.burstcount_o));
                pend_rdy.push_back(cyc + lat);
                bench_outst++;
            end
            if (amm.readdatavalid_i && rdv_last) bench_outst--;
            if (bench_outst > peak) peak = bench_outst;
            prev_wr_stall = amm.write_o && amm.waitrequest_i;
            prev_rd_stall = amm.read_o && amm.waitrequest_i;
            prev_wr_bus   = {amm.write_o, amm.address_o, amm.burstcount_o, amm.writedata_o};
            prev_rd_bus   = {amm.read_o, amm.address_o, amm.burstcount_o};
        end
    end

    task automatic do_reset();
        rst_i = 1'b0;
        pend_addr.delete();
        pend_len.delete();
        pend_rdy.delete();
        exp_wr_q.delete();
        exp_rd_q.delete();
        bench_outst = 0;
        beat = 0;
        wait_en = 1'b0;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_outst", dbg_outst_o, 0);
        check("rst_rw", {amm.read_o, amm.write_o}, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_cnt_o, 0);
        @(negedge clk);
        check("rst_busy_edge", busy_o, 0);
        check("rst_outst_edge", dbg_outst_o, 0);
        check("rst_state_idle", dbg_state_o, 0);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        meas_busy_i = 1'b0;
    endtask

    task automatic run_test(input int mode, input logic [31:0] base, input int len, input int num,
                            input bit wen, input int lt, input int corrupt, input bit spurious,
                            input bit rst_drain, input string tag);
        bit finished;
        int exp_err;
        build_expected(mode, base, len, num);
        wait_en = wen;
        lat = lt;
        corrupt_left = corrupt;
        n_corrupt = 0;
        peak = 0;
        @(posedge clk);
        #1;
        mode_i = 2'(mode);
        base_addr_i = base;
        burst_len_i = BURST_W'(len);
        burst_num_i = 16'(num);
        start_i = 1'b1;
        meas_busy_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        mode_i = 2'($urandom);
        base_addr_i = $urandom;
        burst_len_i = BURST_W'($urandom);
        burst_num_i = 16'($urandom);
        @(negedge clk);
        check({tag, ":meas_start_pulse"}, meas_start_o, 1);
        check({tag, ":busy_after_start"}, busy_o, 1);
        @(posedge clk);
        #1;
        if (spurious) start_i = 1'b1;
        @(negedge clk);
        check({tag, ":meas_start_single"}, meas_start_o, 0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        finished = 1'b0;
        for (int waited = 0; waited < 20000; waited++) begin
            @(negedge clk);
            #1;
            if (rst_drain && exp_rd_q.size() == 0 && bench_outst > 0) begin
                #1;
                do_reset();
                return;
            end
            if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0 && bench_outst == 0 && pend_addr.size() == 0) begin
                finished = 1'b1;
                break;
            end
        end
        check({tag, ":run_complete"}, finished, 1);
        if (!finished) begin
            do_reset();
            return;
        end
        repeat ($urandom_range(2, 4)) @(posedge clk);
        #1;
        meas_busy_i = 1'b0;
`ifdef SEQ_DATA_CHECK_EN
        exp_err = n_corrupt;
`else
        exp_err = 0;
`endif
        @(negedge clk);
        check({tag, ":done_not_early"}, done_o, 0);
        check({tag, ":busy_in_flush"}, busy_o, 1);
        @(negedge clk);
        check({tag, ":done_pulse"}, done_o, 1);
        check({tag, ":err_cnt"}, err_cnt_o, exp_err);
        @(negedge clk);
        check({tag, ":done_single"}, done_o, 0);
        check({tag, ":idle_not_busy"}, busy_o, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_meas_start", meas_start_o, 0);
        check("reset_bus", {amm.read_o, amm.write_o, amm.address_o, amm.burstcount_o,
                            amm.byteenable_o, amm.writedata_o}, 0);
        check("reset_err", err_cnt_o, 0);
        check("reset_outst", dbg_outst_o, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;

        run_test(0, 32'h100, 4, 2, 1'b0, 2, 0, 1'b0, 1'b0, "wr_basic");
        run_test(2, 32'h100, 4, 2, 1'b1, 3, 0, 1'b1, 1'b0, "wr_rd_stall");
        run_test(1, 32'h200, 2, 6, 1'b0, 20, 0, 1'b0, 1'b0, "rd_outst");
        check("peak_outst", peak, MAX_OUTST);
        run_test(2, 32'h40, 3, 3, 1'b1, 4, 3, 1'b0, 1'b0, "corrupt3");
        run_test(0, 32'hFFFF_FFFE, 4, 2, 1'b0, 1, 0, 1'b0, 1'b0, "addr_wrap");
        run_test(1, 32'h300, 2, 6, 1'b0, 20, 0, 1'b0, 1'b1, "rst_drain");
        run_test(2, 32'h500, 2, 2, 1'b1, 2, 0, 1'b0, 1'b0, "after_rst");
        run_test(3, 32'h10, 0, 3, 1'b0, 1, 0, 1'b0, 1'b0, "len0_mode3");
        run_test(2, 32'h10, 5, 0, 1'b0, 1, 0, 1'b1, 1'b0, "num0");
        for (int i = 0; i < 12; i++)
            run_test($urandom_range(0, 3), $urandom, $urandom_range(0, 6), $urandom_range(0, 5),
                     1'($urandom_range(0, 1)), $urandom_range(1, 8), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 1'b0, "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/amm_test_sequencer.md
AMM_TEST_SEQUENCER -- requirements
Module: amm_test_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, Avalon-MM word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 The block SHALL have parameter BURST_W, default 11, burstcount width.
REQ-004 The block SHALL have parameter MAX_OUTST, default 4, the maximum number of outstanding read bursts; the measurement counter has four slots.
REQ-005 The block SHALL have the following ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start pulse from CSR.
- mode_i  in  2  test mode: 0 write-only, 1 read-only, 2 write-then-read, 3 reserved and treated as 2.
- base_addr_i  in  ADDR_W  start word address.
- burst_len_i  in  BURST_W  words per burst; 0 treated as 1.
- burst_num_i  in  16  bursts per phase; 0 means the phase is skipped.
- address_o  out  ADDR_W  Avalon address.
- read_o  out  1  Avalon read.
- write_o  out  1  Avalon write.
- burstcount_o  out  BURST_W  Avalon burstcount.
- byteenable_o  out  DATA_W/8  Avalon byteenable.
- writedata_o  out  DATA_W  Avalon writedata.
- waitrequest_i  in  1  Avalon waitrequest.
- readdatavalid_i  in  1  Avalon readdatavalid.
- readdata_i  in  DATA_W  Avalon readdata.
- meas_start_o  out  1  one-cycle clear pulse to the measurement block.
- meas_busy_i  in  1  measurement block busy.
- busy_o  out  1  high from start until done.
- done_o  out  1  one-cycle completion pulse.
- err_cnt_o  out  32  read-data mismatch count.

Function
REQ-006 The FSM SHALL have the states IDLE, CLEAR, WR_BURST, RD_REQ, RD_DRAIN, FLUSH and DONE.
REQ-007 In IDLE, start_i SHALL latch all configuration inputs, assert meas_start_o for one cycle and enter CLEAR; start_i outside IDLE SHALL be ignored.
REQ-008 CLEAR SHALL last exactly one cycle and then enter WR_BURST (modes 0, 2, 3), RD_REQ (mode 1), or FLUSH if the selected phase has burst_num 0.
REQ-009 WR_BURST SHALL hold write_o high and all write outputs stable while waitrequest_i is high; a word transfers when write_o is high and waitrequest_i is low.
REQ-010 address_o and burstcount_o SHALL hold the burst's first address and length for every word of the burst.
REQ-011 writedata_o SHALL equal the zero-extended word address (address_o + word index in burst); byteenable_o SHALL be all ones.
REQ-012 After the last word of the last write burst, the FSM SHALL enter RD_REQ in modes 2 and 3, or FLUSH in mode 0.
REQ-013 RD_REQ SHALL assert read_o only while outstanding bursts are fewer than MAX_OUTST, and SHALL hold read_o, address_o and burstcount_o stable until waitrequest_i is low.
REQ-014 Outstanding bursts SHALL increment on an accepted read and decrement on the final readdatavalid_i of a burst; a simultaneous increment and decrement SHALL leave the count unchanged.
REQ-015 After the last read request is accepted, the FSM SHALL enter RD_DRAIN, then FLUSH when outstanding reaches 0.
REQ-016 FLUSH SHALL wait until meas_busy_i is low, then enter DONE; DONE SHALL pulse done_o for one cycle and return to IDLE.
REQ-017 The burst address SHALL advance by the effective burst length after each burst and SHALL wrap modulo 2^ADDR_W.
REQ-018 The read phase SHALL restart at the latched base address.
REQ-019 busy_o SHALL be high in every state except IDLE; read_o and write_o SHALL never be high in the same cycle.

Reset
REQ-020 While rst_i is low, the FSM SHALL be in IDLE and all outputs 0, including err_cnt_o and the outstanding count.
REQ-021 Reset asserted mid-burst SHALL abort the burst immediately with no completion pulse.

Configuration
REQ-022 With macro SEQ_DATA_CHECK_EN defined, each readdatavalid_i word SHALL be compared with the expected address pattern, and err_cnt_o SHALL increment by 1 per mismatch, saturate at 32'hFFFF_FFFF, and clear on start_i.
REQ-023 Without SEQ_DATA_CHECK_EN, no compare logic SHALL be present and err_cnt_o SHALL be constant 0.

Verification
REQ-024 Mode 0, base 0x100, len 4, num 2, no waitrequest -> writes to 0x100 then 0x104; writedata 0x100..0x107; done_o 1 cycle after meas_busy_i falls.
REQ-025 Mode 2 with waitrequest high for 3 cycles on the second word -> outputs held stable; total 8 words written, then 2 read bursts issued at 0x100 and 0x104.
REQ-026 Mode 1, num 6, readdatavalid delayed 20 cycles -> at most 4 outstanding; reads 5 and 6 issue only after bursts complete; concurrent accept and completion keeps the count at 4.
REQ-027 With SEQ_DATA_CHECK_EN, a memory model corrupting 3 words -> err_cnt_o = 3; without the macro -> err_cnt_o = 0.
REQ-028 Base 0xFFFF_FFFE, len 4, num 2 -> the second burst starts at 0x0000_0002.
REQ-029 rst_i low during RD_DRAIN -> IDLE, busy_o 0 and outstanding 0 on the next edge; a fresh start_i then runs normally.
